demux_oht_stream: RTL and testbench
===================================

DEMUX_OHT_STREAM -- requirements
Module: demux_oht_stream

Interface
REQ-001 SHALL have parameter DAT_T, default logic [8-1:0], meaning payload data type.
REQ-002 SHALL have parameter WIDTH, default 4, meaning number of output channels (WIDTH>=2).
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port sti_vld  input  1  input beat valid.
REQ-006 SHALL have port sti_rdy  output  1  input beat ready.
REQ-007 SHALL have port sti_oht  input  WIDTH  one-hot destination select for the input beat.
REQ-008 SHALL have port sti_dat  input  DAT_T  input payload.
REQ-009 SHALL have port sto_vld  output  WIDTH  per-channel output valid.
REQ-010 SHALL have port sto_rdy  input  WIDTH  per-channel output ready.
REQ-011 SHALL have port sto_dat  output  DAT_T  payload, shared by all channels.
REQ-012 SHALL have port err  output  1  sticky select-error flag.
REQ-013 SHALL have port err_clr  input  1  synchronous clear of err.

Function
REQ-014 SHALL hold beats in a 2-entry FIFO of {oht, dat}, with head pointer, tail pointer and 2-bit count.
REQ-015 SHALL drive sti_rdy from a register, equal to 1 exactly when count<2; no combinational path from sto_rdy to sti_rdy.
REQ-016 SHALL accept a beat (push) in a cycle where sti_vld & sti_rdy.
REQ-017 SHALL drive sto_vld[i] = (count!=0) & head_oht[i] and sto_dat = head_dat; sto_dat is don't-care when count==0.
REQ-018 SHALL pop the head in a cycle where (count!=0) & |(head_oht & sto_rdy).
REQ-019 SHALL have a latency of 1 cycle: a beat pushed at edge N is visible on sto_* after edge N.
REQ-020 SHALL sustain one beat per cycle when the selected sto_rdy stays high.
REQ-021 SHALL, on simultaneous push and pop, keep count unchanged and advance both pointers.
REQ-022 SHALL wrap pointers modulo 2 and preserve beat order across channels; a stalled head blocks all channels (no reordering).
REQ-023 SHALL keep sto_vld and sto_dat stable while the selected channel is stalled.
REQ-024 SHALL, when err_clr and a new error coincide, leave err at 1 (set wins).

Reset
REQ-025 SHALL, while rst_n=0, asynchronously force count=0, pointers=0, sti_rdy=0, sto_vld=0, err=0.
REQ-026 SHALL raise sti_rdy to 1 on the first rising clk edge after rst_n deasserts.
REQ-027 SHALL discard buffered beats without forwarding them when reset is asserted mid-operation.

Configuration
REQ-028 SHALL support macro DEMUX_OHT_STREAM_CHECK_EN.
REQ-029 SHALL, with DEMUX_OHT_STREAM_CHECK_EN defined:
- accept a pushed beat whose sti_oht is not exactly one-hot (zero-hot or multi-hot)
- not store that beat
- set err=1 on the next edge.
REQ-030 SHALL, without DEMUX_OHT_STREAM_CHECK_EN:
- store every beat
- tie err to 0
- pop a zero-hot head immediately without forwarding it
- pop a multi-hot head when any selected channel is ready, with sto_vld asserted on all selected channels.

Verification
REQ-031 SHALL check reset then single beat: reset released, push oht=4'b0100 dat=8'hA5 with sto_rdy=4'b1111 -> sto_vld=4'b0100, sto_dat=8'hA5 one cycle later, popped the same cycle.
REQ-032 SHALL check back-pressure: sto_rdy=0, push 3 beats -> 2 accepted, sti_rdy=0 from the cycle after the 2nd push; sto_rdy[head]=1 -> sti_rdy=1 the next cycle and order is preserved.
REQ-033 SHALL check streaming: 16 consecutive beats to channels 0,1,2,3 repeating with all sto_rdy=1 -> one beat out per cycle, dat in order, no bubbles after the first.
REQ-034 SHALL check head-of-line blocking: head to channel 1 with sto_rdy=4'b1101 -> next beat to channel 0 is not presented until sto_rdy[1]=1.
REQ-035 SHALL check the error path with CHECK_EN: push oht=4'b0110 -> beat dropped, err=1; err_clr=1 for one cycle -> err=0. Without CHECK_EN, same push -> sto_vld=4'b0110 and err=0.
REQ-036 SHALL check mid-operation reset: rst_n=0 with count=2 -> sto_vld=0 and sti_rdy=0 immediately without waiting for clk; no stale beat appears after release.

Source files
------------

// File: rtl/demux_oht_stream.sv
// demux_oht_stream: one-hot addressed stream demultiplexer with a 2-entry
// {oht, dat} skid FIFO. Beats leave in arrival order on the channel(s) named
// by their one-hot select; a stalled head blocks every channel.
//
// Optional feature macro: DEMUX_OHT_STREAM_CHECK_EN
//   defined   : beats whose select is not exactly one-hot are accepted but
//               dropped, and the sticky err flag is raised (cleared by err_clr,
//               a coincident new error wins).
//   undefined : every beat is stored, err is tied low, a zero-hot head is
//               popped without being forwarded, a multi-hot head is shown on
//               all selected channels and pops when any of them is ready.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   sti_vld/sti_rdy   input handshake (sti_rdy is a register, count<2)
//   sti_oht, sti_dat  one-hot destination and payload of the input beat
//   sto_vld/sto_rdy   per-channel output handshake
//   sto_dat           payload of the head beat, shared by all channels
//   err, err_clr      sticky select-error flag and its synchronous clear
module demux_oht_stream #(
   parameter type         DAT_T = logic [8-1:0],
   parameter int unsigned WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             sti_vld,
   output logic             sti_rdy,
   input  logic [WIDTH-1:0] sti_oht,
   input  DAT_T             sti_dat,
   output logic [WIDTH-1:0] sto_vld,
   input  logic [WIDTH-1:0] sto_rdy,
   output DAT_T             sto_dat,
   output logic             err,
   input  logic             err_clr
);

   localparam int unsigned DEPTH = 2;

   // FIFO storage and control
   logic [WIDTH-1:0] oht_q [0:DEPTH-1];
   DAT_T             dat_q [0:DEPTH-1];
   logic             hd_ptr_q;
   logic             tl_ptr_q;
   logic [1:0]       cnt_q;
   logic             rdy_q;

   logic             push_c;
   logic             store_c;
   logic             pop_c;
   logic             nonempty_c;
   logic [WIDTH-1:0] head_oht_c;
   logic [1:0]       cnt_nxt_c;
   logic             hd_ptr_nxt_c;
   logic             tl_ptr_nxt_c;
   logic             rdy_nxt_c;

   // Next-state: handshake decode, pointer and count update
   always_comb begin
      push_c       = 1'b0;
      store_c      = 1'b0;
      pop_c        = 1'b0;
      nonempty_c   = 1'b0;
      head_oht_c   = '0;
      cnt_nxt_c    = cnt_q;
      hd_ptr_nxt_c = hd_ptr_q;
      tl_ptr_nxt_c = tl_ptr_q;
      rdy_nxt_c    = 1'b0;

      push_c     = sti_vld & rdy_q;
`ifdef DEMUX_OHT_STREAM_CHECK_EN
      store_c    = push_c & (sti_oht != '0) & ((sti_oht & (sti_oht - WIDTH'(1))) == '0);
`else
      store_c    = push_c;
`endif
      nonempty_c = (cnt_q != 2'd0);
      head_oht_c = oht_q[hd_ptr_q];
      // A zero-hot head has no consumer, so it is retired without forwarding.
      pop_c      = nonempty_c & ((head_oht_c == '0) | (|(head_oht_c & sto_rdy)));

      cnt_nxt_c    = cnt_q + 2'(store_c) - 2'(pop_c);
      hd_ptr_nxt_c = hd_ptr_q ^ pop_c;
      tl_ptr_nxt_c = tl_ptr_q ^ store_c;
      rdy_nxt_c    = (cnt_nxt_c < 2'(DEPTH));
   end

   // Control registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hd_ptr_q <= 1'b0;
         tl_ptr_q <= 1'b0;
         cnt_q    <= 2'd0;
         rdy_q    <= 1'b0;
      end else begin
         hd_ptr_q <= hd_ptr_nxt_c;
         tl_ptr_q <= tl_ptr_nxt_c;
         cnt_q    <= cnt_nxt_c;
         rdy_q    <= rdy_nxt_c;
      end
   end

   // Payload storage needs no reset; validity comes from cnt_q
   always_ff @(posedge clk) begin
      if (store_c) begin
         oht_q[tl_ptr_q] <= sti_oht;
         dat_q[tl_ptr_q] <= sti_dat;
      end
   end

   assign sti_rdy = rdy_q;
   assign sto_vld = {WIDTH{nonempty_c}} & head_oht_c;
   assign sto_dat = dat_q[hd_ptr_q];

`ifdef DEMUX_OHT_STREAM_CHECK_EN
   logic err_q;

   // Sticky error flag; a new error outranks a coincident clear
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_q <= 1'b0;
      end else begin
         err_q <= (push_c & ~store_c) | (err_q & ~err_clr);
      end
   end

   assign err = err_q;
`else
   logic unused_err_clr;

   assign unused_err_clr = err_clr;
   assign err            = 1'b0;
`endif

endmodule

// File: tb/tb_demux_oht_stream.sv
module tb_demux_oht_stream;

   localparam int unsigned WIDTH = 4;

   logic             clk;
   logic             rst_n;
   logic             sti_vld;
   logic             sti_rdy;
   logic [WIDTH-1:0] sti_oht;
   logic [7:0]       sti_dat;
   logic [WIDTH-1:0] sto_vld;
   logic [WIDTH-1:0] sto_rdy;
   logic [7:0]       sto_dat;
   logic             err;
   logic             err_clr;

   int checks = 0;
   int errors = 0;

   demux_oht_stream #(
      .DAT_T (logic [7:0]),
      .WIDTH (WIDTH)
   ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .sti_vld (sti_vld),
      .sti_rdy (sti_rdy),
      .sti_oht (sti_oht),
      .sti_dat (sti_dat),
      .sto_vld (sto_vld),
      .sto_rdy (sto_rdy),
      .sto_dat (sto_dat),
      .err     (err),
      .err_clr (err_clr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one rising edge and settle 1 time unit past it
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; sti_vld = 1'b0; sti_oht = '0; sti_dat = '0;
      sto_rdy = '0; err_clr = 1'b0;
      tick(); tick();
      checks++; if (sti_rdy !== 1'b0) begin errors++; $display("FAIL reset_rdy: got %b expected 0", sti_rdy); end
      checks++; if (sto_vld !== 4'b0000) begin errors++; $display("FAIL reset_vld: got %b expected 0000", sto_vld); end
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", err); end
      rst_n = 1'b1;
      #2;
      checks++; if (sti_rdy !== 1'b0) begin errors++; $display("FAIL release_rdy_early: got %b expected 0", sti_rdy); end
      tick();
      checks++; if (sti_rdy !== 1'b1) begin errors++; $display("FAIL release_rdy: got %b expected 1", sti_rdy); end
   endtask

   task automatic test_single();
      sto_rdy = 4'b1111;
      sti_vld = 1'b1; sti_oht = 4'b0100; sti_dat = 8'hA5;
      tick();
      sti_vld = 1'b0;
      checks++; if (sto_vld !== 4'b0100) begin errors++; $display("FAIL single_vld: got %b expected 0100", sto_vld); end
      checks++; if (sto_dat !== 8'hA5) begin errors++; $display("FAIL single_dat: got %h expected a5", sto_dat); end
      tick();
      checks++; if (sto_vld !== 4'b0000) begin errors++; $display("FAIL single_pop: got %b expected 0000", sto_vld); end
      checks++; if (sti_rdy !== 1'b1) begin errors++; $display("FAIL single_rdy: got %b expected 1", sti_rdy); end
   endtask

   task automatic test_backpressure();
      sto_rdy = 4'b0000;
      sti_vld = 1'b1; sti_oht = 4'b0001; sti_dat = 8'h11;
      tick();
      checks++; if (sti_rdy !== 1'b1) begin errors++; $display("FAIL bp_rdy_after1: got %b expected 1", sti_rdy); end
      sti_oht = 4'b0010; sti_dat = 8'h22;
      tick();
      checks++; if (sti_rdy !== 1'b0) begin errors++; $display("FAIL bp_rdy_full: got %b expected 0", sti_rdy); end
      sti_oht = 4'b0100; sti_dat = 8'h33;
      tick();
      sti_vld = 1'b0;
      checks++; if (sto_vld !== 4'b0001) begin errors++; $display("FAIL bp_head_vld: got %b expected 0001", sto_vld); end
      checks++; if (sto_dat !== 8'h11) begin errors++; $display("FAIL bp_head_dat: got %h expected 11", sto_dat); end
      sto_rdy = 4'b0001;
      #2;
      checks++; if (sti_rdy !== 1'b0) begin errors++; $display("FAIL bp_no_comb_path: got %b expected 0", sti_rdy); end
      tick();
      checks++; if (sti_rdy !== 1'b1) begin errors++; $display("FAIL bp_rdy_back: got %b expected 1", sti_rdy); end
      checks++; if (sto_vld !== 4'b0010) begin errors++; $display("FAIL bp_second_vld: got %b expected 0010", sto_vld); end
      checks++; if (sto_dat !== 8'h22) begin errors++; $display("FAIL bp_second_dat: got %h expected 22", sto_dat); end
      sto_rdy = 4'b0010;
      tick();
      checks++; if (sto_vld !== 4'b0000) begin errors++; $display("FAIL bp_third_dropped: got %b expected 0000", sto_vld); end
   endtask

   task automatic test_streaming();
      logic [WIDTH-1:0] exp_oht;
      logic [7:0]       exp_dat;
      sto_rdy = 4'b1111;
      for (int i = 0; i < 16; i++) begin
         exp_oht = WIDTH'(1) << (i % 4);
         exp_dat = 8'h40 + 8'(i);
         sti_vld = 1'b1; sti_oht = exp_oht; sti_dat = exp_dat;
         tick();
         checks++; if (sto_vld !== exp_oht || sto_dat !== exp_dat || sti_rdy !== 1'b1) begin
            errors++;
            $display("FAIL stream_beat%0d: got vld=%b dat=%h rdy=%b expected vld=%b dat=%h rdy=1",
                     i, sto_vld, sto_dat, sti_rdy, exp_oht, exp_dat);
         end
      end
      sti_vld = 1'b0;
      tick();
      checks++; if (sto_vld !== 4'b0000) begin errors++; $display("FAIL stream_drain: got %b expected 0000", sto_vld); end
   endtask

   task automatic test_hol();
      sto_rdy = 4'b1101;
      sti_vld = 1'b1; sti_oht = 4'b0010; sti_dat = 8'hB1;
      tick();
      sti_oht = 4'b0001; sti_dat = 8'hB2;
      tick();
      sti_vld = 1'b0;
      for (int i = 0; i < 3; i++) begin
         checks++; if (sto_vld !== 4'b0010 || sto_dat !== 8'hB1) begin
            errors++;
            $display("FAIL hol_stall%0d: got vld=%b dat=%h expected vld=0010 dat=b1", i, sto_vld, sto_dat);
         end
         tick();
      end
      sto_rdy = 4'b1111;
      tick();
      checks++; if (sto_vld !== 4'b0001 || sto_dat !== 8'hB2) begin
         errors++;
         $display("FAIL hol_release: got vld=%b dat=%h expected vld=0001 dat=b2", sto_vld, sto_dat);
      end
      tick();
      checks++; if (sto_vld !== 4'b0000) begin errors++; $display("FAIL hol_drain: got %b expected 0000", sto_vld); end
   endtask

   task automatic test_error();
      sto_rdy = 4'b0000;
      sti_vld = 1'b1; sti_oht = 4'b0110; sti_dat = 8'hC3;
      tick();
      sti_vld = 1'b0;
`ifdef DEMUX_OHT_STREAM_CHECK_EN
      checks++; if (sto_vld !== 4'b0000) begin errors++; $display("FAIL err_dropped: got %b expected 0000", sto_vld); end
      checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_set: got %b expected 1", err); end
      tick();
      checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_sticky: got %b expected 1", err); end
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL err_clear: got %b expected 0", err); end
      err_clr = 1'b1; sti_vld = 1'b1; sti_oht = 4'b0011;
      tick();
      err_clr = 1'b0; sti_vld = 1'b0;
      checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_set_wins: got %b expected 1", err); end
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
`else
      checks++; if (sto_vld !== 4'b0110 || sto_dat !== 8'hC3) begin
         errors++;
         $display("FAIL multihot_fwd: got vld=%b dat=%h expected vld=0110 dat=c3", sto_vld, sto_dat);
      end
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL err_tied: got %b expected 0", err); end
      sto_rdy = 4'b0100;
      tick();
      sto_rdy = 4'b0000;
      checks++; if (sto_vld !== 4'b0000) begin errors++; $display("FAIL multihot_pop: got %b expected 0000", sto_vld); end
`endif
      // Zero-hot beat followed by a valid beat: only the valid one is ever shown
      sti_vld = 1'b1; sti_oht = 4'b0000; sti_dat = 8'hD0;
      tick();
      checks++; if (sto_vld !== 4'b0000) begin errors++; $display("FAIL zerohot_hidden: got %b expected 0000", sto_vld); end
      sti_oht = 4'b1000; sti_dat = 8'hD1;
      tick();
      sti_vld = 1'b0;
      checks++; if (sto_vld !== 4'b1000 || sto_dat !== 8'hD1) begin
         errors++;
         $display("FAIL zerohot_skipped: got vld=%b dat=%h expected vld=1000 dat=d1", sto_vld, sto_dat);
      end
`ifdef DEMUX_OHT_STREAM_CHECK_EN
      checks++; if (err !== 1'b1) begin errors++; $display("FAIL zerohot_err: got %b expected 1", err); end
      err_clr = 1'b1;
`else
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL zerohot_err: got %b expected 0", err); end
`endif
      sto_rdy = 4'b1000;
      tick();
      err_clr = 1'b0;
      checks++; if (sto_vld !== 4'b0000 || err !== 1'b0) begin
         errors++;
         $display("FAIL err_final: got vld=%b err=%b expected vld=0000 err=0", sto_vld, err);
      end
   endtask

   task automatic test_mid_reset();
      sto_rdy = 4'b0000;
      sti_vld = 1'b1; sti_oht = 4'b0001; sti_dat = 8'hE1;
      tick();
      sti_oht = 4'b0010; sti_dat = 8'hE2;
      tick();
      sti_vld = 1'b0;
      checks++; if (sto_vld !== 4'b0001 || sti_rdy !== 1'b0) begin
         errors++;
         $display("FAIL mrst_full: got vld=%b rdy=%b expected vld=0001 rdy=0", sto_vld, sti_rdy);
      end
      #2;
      rst_n = 1'b0;
      #1;
      checks++; if (sto_vld !== 4'b0000 || sti_rdy !== 1'b0) begin
         errors++;
         $display("FAIL mrst_async: got vld=%b rdy=%b expected vld=0000 rdy=0", sto_vld, sti_rdy);
      end
      tick();
      sto_rdy = 4'b1111;
      rst_n = 1'b1;
      tick();
      checks++; if (sti_rdy !== 1'b1 || sto_vld !== 4'b0000) begin
         errors++;
         $display("FAIL mrst_release: got vld=%b rdy=%b expected vld=0000 rdy=1", sto_vld, sti_rdy);
      end
      tick();
      checks++; if (sto_vld !== 4'b0000) begin errors++; $display("FAIL mrst_no_stale: got %b expected 0000", sto_vld); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_backpressure();
      test_streaming();
      test_hol();
      test_error();
      test_mid_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
